inst_buffer: RTL
================

Name: inst_buffer

Overview:
- Circular instruction queue between fetch/decode and the R10K dispatch/rename logic.
- Accepts up to N_WAY decoded instructions per cycle and presents the N_WAY oldest as a dispatch_packet vector with a matching branch_inst mask.
- Retires entries using the in-order dispatched mask returned by the ROB.
- Flushes completely on branch_haz so fetch can redirect.

Parameters:
N_WAY, 2, superscalar width; lane count on both enqueue and dequeue
DEPTH, 8, entries; power of two, must be >= 2*N_WAY
PTR_W, $clog2(DEPTH), pointer width
CNT_W, $clog2(DEPTH)+1, occupancy counter width

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
if_packet  in  N_WAY x DISPATCH_PACKET_R10K  decoded instructions from fetch/decode; lane 0 is oldest
if_branch  in  N_WAY  per-lane "is branch" flag
if_ready  out  1  buffer can take a full N_WAY group this cycle
dispatched  in  N_WAY  per-lane "consumed" mask from the ROB
branch_haz  in  1  mispredict flush
dispatch_packet  out  N_WAY x DISPATCH_PACKET_R10K  oldest entries; .valid marks presence
branch_inst  out  N_WAY  branch flag of each presented lane; 0 when the lane is invalid
count  out  CNT_W  current occupancy (debug)

Behaviour:
- State: entry array (packet + branch bit), head, tail, count registers.
- Reset (highest priority): head=tail=count=0; all dispatch_packet.valid=0; branch_inst=0; if_ready=1. Entry contents are don't-care.
- Output path is combinational from the registers:
  - Lane i shows entry[(head+i) mod DEPTH].
  - Valid only when i < count; invalid lanes drive all-zero packets.
- Dequeue count deq_n:
  - Leading run of ones in (dispatched & presented-valid), starting at lane 0.
  - Bits after the first zero are ignored.
  - head += deq_n, modulo DEPTH.
- Enqueue count enq_n:
  - Leading run of if_packet[i].valid from lane 0.
  - Lanes after the first invalid lane are dropped.
  - enq_n = 0 when if_ready=0.
  - Entries written at tail..tail+enq_n-1 modulo DEPTH; tail += enq_n.
- if_ready = (DEPTH - count) >= N_WAY.
  - Computed from registered count only; same-cycle dequeue is not credited (no bypass).
- count_next = count + enq_n - deq_n. Simultaneous enqueue and dequeue is legal in the same cycle.
- Latency:
  - An enqueued instruction is first visible on dispatch_packet the cycle after acceptance.
  - A dequeued entry disappears the next cycle, and the remaining entries shift down to lane 0.
- Flush: branch_haz=1 at a clock edge sets head=tail=count=0.
  - That cycle's enqueue and dequeue are discarded.
  - The next cycle shows all lanes invalid and if_ready=1.
- Boundaries:
  - Full (count=DEPTH): if_ready=0; outputs unaffected.
  - Empty: all lanes invalid; dispatched is ignored.
  - Pointer wrap: head+i and tail+i wrap modulo DEPTH; a group may straddle index DEPTH-1/0.
  - Overflow/underflow are impossible by construction. Assertions: count never exceeds DEPTH; deq_n never exceeds count.
- Ordering: program order is preserved lane-to-lane and cycle-to-cycle.

Decomposition:
- Shared package/header: DISPATCH_PACKET_R10K (existing); a new IB_ENTRY struct {DISPATCH_PACKET_R10K pkt; logic is_branch;}; `N_WAY and `IB_DEPTH macros alongside the existing `N_WAY/`N_RS.
- One natural sub-module: prefix_count.
  - Generic N-bit "leading ones" counter.
  - Instantiated twice: once for deq_n (dispatched & valid), once for enq_n (input valids).
- Pointer arithmetic and storage stay in inst_buffer.

Test Plan:
- Reset fill: reset, then enqueue A,B (branch flag on B) -> next cycle lanes 0/1 = A/B valid, branch_inst=2'b10, count=2, if_ready=1.
- Partial dispatch: buffer holds A,B,C; dispatched=2'b01 -> next cycle lane0=B, lane1=C, count=2. Then dispatched=2'b10 (non-prefix) -> no dequeue, count stays 2.
- Fill to full: enqueue 2/cycle with dispatched=0 for 4 cycles -> count=8, if_ready=0. A fifth group offered is dropped and count stays 8.
- Wrap-around: keep 6 entries in flight and stream 20 instructions with IDs 0..19 at enq=2/deq=2 per cycle -> output ID sequence strictly 0..19 across the DEPTH-1/0 boundary, no gaps or duplicates.
- Flush with simultaneous traffic: count=5, with enqueue of 2, dispatched=2'b11 and branch_haz=1 in the same cycle -> next cycle count=0, all lanes invalid, if_ready=1. The following enqueue of X appears in lane 0.
- Reset mid-operation: count=6 with traffic active; assert reset for 1 cycle -> count=0, outputs zero, head/tail=0. Pre-reset entries never reappear.

Source files
------------

// File: rtl/inst_buffer_pkg.sv
// inst_buffer_pkg
//   Shared types and sizing for the instruction buffer that sits between
//   fetch/decode and R10K dispatch/rename.
//   - DISPATCH_PACKET_R10K : decoded instruction handed to dispatch
//   - IB_ENTRY             : one buffer slot (packet + branch flag)
//   - IB_N_WAY / IB_DEPTH_DEF : defaults taken from the `N_WAY / `IB_DEPTH macros

`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef N_RS
`define N_RS 16
`endif
`ifndef IB_DEPTH
`define IB_DEPTH 8
`endif

package inst_buffer_pkg;

    localparam int IB_N_WAY     = `N_WAY;
    localparam int IB_DEPTH_DEF = `IB_DEPTH;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  dest_reg_idx;
    } DISPATCH_PACKET_R10K;

    typedef struct packed {
        DISPATCH_PACKET_R10K pkt;
        logic                is_branch;
    } IB_ENTRY;

endpackage

// File: rtl/inst_buffer_prefix_count.sv
// inst_buffer_prefix_count
//   Counts the leading run of ones starting at bit 0; everything after the
//   first zero is ignored.
//   Ports:
//     bits  in  N  input mask, bit 0 first
//     count out W  length of the leading run of ones (0..N)

module inst_buffer_prefix_count #(
    parameter int N = 2,
    parameter int W = $clog2(N + 1)
) (
    input  logic [N-1:0] bits,
    output logic [W-1:0] count
);

    logic run;

    always_comb begin
        count = '0;
        run   = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (run && bits[i]) begin
                count = count + W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/inst_buffer.sv
// inst_buffer
//   Circular instruction queue between fetch/decode and R10K dispatch.
//   Takes up to N_WAY decoded instructions per cycle, presents the N_WAY
//   oldest to dispatch, retires the in-order prefix the ROB reports as
//   dispatched, and empties completely on branch_haz.
//   Ports:
//     clock, reset     clock; synchronous active-high reset
//     if_packet        N_WAY decoded instructions, lane 0 oldest
//     if_branch        per-lane branch flag for if_packet
//     if_ready         room for a full N_WAY group this cycle
//     dispatched       per-lane consumed mask from the ROB
//     branch_haz       mispredict flush
//     dispatch_packet  N_WAY oldest entries, all-zero when lane not present
//     branch_inst      branch flag of each presented lane
//     count            current occupancy

module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int N_WAY = IB_N_WAY,
    parameter int DEPTH = IB_DEPTH_DEF,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  DISPATCH_PACKET_R10K [N_WAY-1:0] if_packet,
    input  logic [N_WAY-1:0]                if_branch,
    output logic                            if_ready,
    input  logic [N_WAY-1:0]                dispatched,
    input  logic                            branch_haz,
    output DISPATCH_PACKET_R10K [N_WAY-1:0] dispatch_packet,
    output logic [N_WAY-1:0]                branch_inst,
    output logic [CNT_W-1:0]                count
);

    localparam int LANE_W = $clog2(N_WAY + 1);
    // Highest occupancy that still leaves room for a full group.
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - N_WAY);

    IB_ENTRY            mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;

    logic [N_WAY-1:0]   lane_valid;
    logic [N_WAY-1:0]   deq_mask;
    logic [N_WAY-1:0]   enq_valid;
    logic [N_WAY-1:0]   enq_we;
    logic [LANE_W-1:0]  deq_n;
    logic [LANE_W-1:0]  enq_raw;
    logic [LANE_W-1:0]  enq_n;

    // Registered count only: a dequeue in the same cycle does not free room.
    assign if_ready = (count <= READY_MAX);

    for (genvar i = 0; i < N_WAY; i++) begin : g_lane
        localparam logic [PTR_W-1:0]  OFS    = PTR_W'(i);
        localparam logic [CNT_W-1:0]  LANE_C = CNT_W'(i);
        localparam logic [LANE_W-1:0] LANE_L = LANE_W'(i);

        IB_ENTRY rd;

        // Pointer width equals log2(DEPTH), so the add wraps modulo DEPTH.
        assign rd                 = mem[head + OFS];
        assign lane_valid[i]      = (LANE_C < count);
        assign dispatch_packet[i] = lane_valid[i] ? rd.pkt : '0;
        assign branch_inst[i]     = lane_valid[i] & rd.is_branch;

        assign deq_mask[i]  = dispatched[i] & lane_valid[i];
        assign enq_valid[i] = if_packet[i].valid;
        assign enq_we[i]    = (LANE_L < enq_n);
    end

    inst_buffer_prefix_count #(.N(N_WAY), .W(LANE_W)) u_deq_cnt (
        .bits  (deq_mask),
        .count (deq_n)
    );

    inst_buffer_prefix_count #(.N(N_WAY), .W(LANE_W)) u_enq_cnt (
        .bits  (enq_valid),
        .count (enq_raw)
    );

    assign enq_n = if_ready ? enq_raw : '0;

    always_ff @(posedge clock) begin
        if (reset || branch_haz) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(deq_n);
            tail  <= tail + PTR_W'(enq_n);
            count <= count + CNT_W'(enq_n) - CNT_W'(deq_n);
        end
    end

    // Storage carries no reset; presence is tracked by head/count alone.
    always_ff @(posedge clock) begin
        if (!reset && !branch_haz) begin
            for (int i = 0; i < N_WAY; i++) begin
                if (enq_we[i]) begin
                    mem[tail + PTR_W'(i)] <= IB_ENTRY'{pkt: if_packet[i], is_branch: if_branch[i]};
                end
            end
        end
    end

    ap_count_bound : assert property (@(posedge clock) disable iff (reset)
        count <= CNT_W'(DEPTH));

    ap_deq_bound : assert property (@(posedge clock) disable iff (reset)
        CNT_W'(deq_n) <= count);

endmodule
